// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction fetch path.
package mips_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;

  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic addr_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetched {pc, instr} pairs; flush wins over push.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  fetch_entry_t     wr_entry_i,
  output fetch_entry_t     head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [FIFO_DEPTH];
  logic             rd_ptr_q;
  logic             wr_ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic full_c;
  logic do_pop_c;
  logic do_push_c;

  assign full_c    = (cnt_q == CNT_W'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_c || do_pop_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= wr_entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop_c) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push_c, do_pop_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives instruction memory, buffers pairs toward decode,
// handles redirects and latches a sticky fault on bad fetch addresses.
module instr_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned       MEM_WORDS = 1024,
  parameter int unsigned       BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_instr,
  input  logic              redirect_vld,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instr,
  output logic [WORD_W-1:0] out_pc,
  output logic              fault,
  output logic [WORD_W-1:0] fault_pc,
  output logic [WORD_W-1:0] retired_cnt
);

  fetch_state_e      state_q;
  logic [WORD_W-1:0] fetch_pc_q;
  logic [WORD_W-1:0] fault_pc_q;
  logic [WORD_W-1:0] retired_q;

  fetch_entry_t      fifo_head;
  fetch_entry_t      fifo_wr;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  logic in_run_c;
  logic pop_c;
  logic slot_c;
  logic out_of_range_c;
  logic push_try_c;
  logic push_c;
  logic push_fault_c;
  logic flush_c;

  // A push is only "attempted" when there is room; the range check applies to that attempt.
  assign in_run_c       = (state_q == ST_RUN);
  assign pop_c          = !fifo_empty && out_ready;
  assign slot_c         = (fifo_count != CNT_W'(BUF_DEPTH)) || pop_c;
  assign out_of_range_c = (fetch_pc_q >> 2) >= WORD_W'(MEM_WORDS);
  assign push_try_c     = in_run_c && !redirect_vld && slot_c;
  assign push_c         = push_try_c && !out_of_range_c;
  assign push_fault_c   = push_try_c && out_of_range_c;
  assign flush_c        = in_run_c && redirect_vld;

  assign fifo_wr.pc    = fetch_pc_q;
  assign fifo_wr.instr = imem_instr;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_c),
    .pop_i      (pop_c),
    .flush_i    (flush_c),
    .wr_entry_i (fifo_wr),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      fault_pc_q <= '0;
      retired_q  <= '0;
    end else begin
      if (pop_c) retired_q <= retired_q + WORD_W'(1);
      case (state_q)
        ST_RUN: begin
          if (redirect_vld) begin
            if (addr_misaligned(redirect_pc)) begin
              state_q    <= ST_FAULT;
              fault_pc_q <= redirect_pc;
            end else begin
              fetch_pc_q <= redirect_pc;
            end
          end else if (push_fault_c) begin
            state_q    <= ST_FAULT;
            fault_pc_q <= fetch_pc_q;
          end else if (push_c) begin
            fetch_pc_q <= fetch_pc_q + WORD_W'(4);
          end
        end
        default: begin
          state_q <= ST_FAULT;
        end
      endcase
    end
  end

  // Memory sees the reset vector even before the first reset edge has landed.
  assign imem_addr   = reset ? RESET_PC : fetch_pc_q;
  assign out_valid   = !fifo_empty;
  assign out_pc      = fifo_head.pc;
  assign out_instr   = fifo_head.instr;
  assign fault       = (state_q == ST_FAULT);
  assign fault_pc    = fault_pc_q;
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed, table-driven bench for instr_fetch_ctrl with a small second instance for end-of-memory.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic [31:0] imem_addr, imem_instr, out_instr, out_pc, fault_pc, retired_cnt;
  logic        out_valid, fault;

  logic [31:0] s_imem_addr, s_imem_instr, s_out_instr, s_out_pc, s_fault_pc, s_retired_cnt;
  logic        s_out_valid, s_fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_instr   = mem_word(imem_addr);
  assign s_imem_instr = mem_word(s_imem_addr);

  instr_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(1024), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc), .retired_cnt(retired_cnt)
  );

  instr_fetch_ctrl #(.RESET_PC(32'h0), .MEM_WORDS(16), .BUF_DEPTH(2)) dut_small (
    .clk(clk), .reset(reset), .imem_addr(s_imem_addr), .imem_instr(s_imem_instr),
    .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_instr(s_out_instr), .out_pc(s_out_pc),
    .fault(s_fault), .fault_pc(s_fault_pc), .retired_cnt(s_retired_cnt)
  );

  typedef struct {
    logic        rst;
    logic        rdv;
    logic [31:0] rdpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic        ef;
    logic [31:0] efpc;
    logic [31:0] eret;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic rdv, input logic [31:0] rdpc, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                     input logic ef, input logic [31:0] efpc, input logic [31:0] eret);
    vec_t v;
    v.rst = rst; v.rdv = rdv; v.rdpc = rdpc; v.rdy = rdy; v.ev = ev; v.epc = epc;
    v.eaddr = eaddr; v.ef = ef; v.efpc = efpc; v.eret = eret;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // straight-line, 8+ handshakes
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 9; c++)
      add(0, 0, 0, 1, 1, 32'(4 * (c - 1)), 32'(4 * c), 0, 0, 32'(c - 1));
    // reset, then backpressure
    add(1, 0, 0, 0, 1, 32'd36, 32'd0, 0, 0, 32'd9);
    add(0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'd0, 32'd4, 0, 0, 0);
    for (int c = 0; c < 3; c++) add(0, 0, 0, 0, 1, 32'd0, 32'd8, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'd0, 32'd8, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'd4, 32'd12, 0, 0, 32'd1);
    // redirect to 0x40 while head 0x8 is accepted
    add(0, 1, 32'h40, 1, 1, 32'd8, 32'd16, 0, 0, 32'd2);
    add(0, 0, 0, 1, 0, 0, 32'h40, 0, 0, 32'd3);
    add(0, 0, 0, 1, 1, 32'h40, 32'h44, 0, 0, 32'd3);
    // back-to-back redirects, the second wins
    add(0, 1, 32'h100, 1, 1, 32'h44, 32'h48, 0, 0, 32'd4);
    add(0, 1, 32'h200, 1, 0, 0, 32'h100, 0, 0, 32'd5);
    add(0, 0, 0, 1, 0, 0, 32'h200, 0, 0, 32'd5);
    add(0, 0, 0, 1, 1, 32'h200, 32'h204, 0, 0, 32'd5);
    // misaligned redirect faults; later redirects ignored
    add(0, 1, 32'h42, 0, 1, 32'h204, 32'h208, 0, 0, 32'd6);
    add(0, 1, 32'h80, 1, 0, 0, 32'h208, 1, 32'h42, 32'd6);
    add(0, 0, 0, 1, 0, 0, 32'h208, 1, 32'h42, 32'd6);
    add(1, 0, 0, 0, 0, 0, 32'd0, 1, 32'h42, 32'd6);
    // fill FIFO, then reset with a would-be handshake
    add(0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'd0, 32'd4, 0, 0, 0);
    add(1, 0, 0, 1, 1, 32'd0, 32'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'd0, 32'd4, 0, 0, 0);

    reset = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk); #1;
    chk("rst_addr",    -1, imem_addr, 32'h0);
    chk("rst_valid",   -1, 32'(out_valid), 32'h0);
    chk("rst_pc",      -1, out_pc, 32'h0);
    chk("rst_instr",   -1, out_instr, 32'h0);
    chk("rst_fault",   -1, 32'(fault), 32'h0);
    chk("rst_faultpc", -1, fault_pc, 32'h0);
    chk("rst_retired", -1, retired_cnt, 32'h0);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; redirect_vld = tbl[i].rdv;
      redirect_pc = tbl[i].rdpc; out_ready = tbl[i].rdy;
      #1;
      chk("valid",   i, 32'(out_valid), 32'(tbl[i].ev));
      chk("addr",    i, imem_addr, tbl[i].eaddr);
      chk("fault",   i, 32'(fault), 32'(tbl[i].ef));
      chk("faultpc", i, fault_pc, tbl[i].efpc);
      chk("retired", i, retired_cnt, tbl[i].eret);
      if (tbl[i].ev) begin
        chk("pc",    i, out_pc, tbl[i].epc);
        chk("instr", i, out_instr, mem_word(tbl[i].epc));
      end
      @(negedge clk); #1;
    end

    // end of a 16-word memory: 0x3C is the last delivery, then fault at 0x40
    reset = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      chk("eom_valid",   c, 32'(s_out_valid), 32'((c >= 1 && c <= 16) ? 1 : 0));
      chk("eom_fault",   c, 32'(s_fault), 32'((c >= 17) ? 1 : 0));
      chk("eom_faultpc", c, s_fault_pc, (c >= 17) ? 32'h40 : 32'h0);
      chk("eom_addr",    c, s_imem_addr, (c <= 16) ? 32'(4 * c) : 32'h40);
      if (c >= 1 && c <= 16) begin
        chk("eom_pc",    c, s_out_pc, 32'(4 * (c - 1)));
        chk("eom_instr", c, s_out_instr, mem_word(32'(4 * (c - 1))));
      end
      if (c == 19) chk("eom_retired", c, s_retired_cnt, 32'd16);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
